// File: rtl/sram_like_arbiter_if.sv
// rtl/sram_like_arbiter_if.sv - IF/MEM requester and memory-side SRAM-like handshake bundle
interface sram_like_arbiter_if;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic [31:0] inst_wdata;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  logic        s_req;
  logic        s_wr;
  logic [1:0]  s_size;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic        s_addr_ok;
  logic        s_data_ok;
  logic [31:0] s_rdata;

  // slave: the arbiter's view (serves the pipeline, drives the memory side)
  modport slave (
    input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata,
    output s_req, s_wr, s_size, s_addr, s_wdata,
    input  s_addr_ok, s_data_ok, s_rdata
  );

  modport master (
    output inst_req, inst_wr, inst_size, inst_addr, inst_wdata,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata,
    input  s_req, s_wr, s_size, s_addr, s_wdata,
    output s_addr_ok, s_data_ok, s_rdata
  );
endinterface

// File: rtl/sram_like_arbiter.sv
// rtl/sram_like_arbiter.sv - data-priority arbiter for one SRAM-like port with in-order owner FIFO
module sram_like_arbiter #(
  parameter int DEPTH   = 4,
  parameter int DEPTH_W = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  sram_like_arbiter_if.slave   bus,
  output logic                 err_unexp
);

  typedef enum logic [1:0] {IDLE, HOLD_I, HOLD_D} state_t;
  typedef enum logic [1:0] {G_NONE, G_INST, G_DATA} grant_t;

  state_t             state, state_nxt;
  grant_t             grant;
  logic [DEPTH-1:0]   owner_q;
  logic [DEPTH_W-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_W:0]   count;
  logic               full, push, pop, head_owner;

  assign full       = (count == (DEPTH_W+1)'(DEPTH));
  assign head_owner = owner_q[rd_ptr];
  assign pop        = bus.s_data_ok && (count != '0) && !reset;

  always_comb begin
    state_nxt   = state;
    grant       = G_NONE;
    bus.s_req   = 1'b0;
    bus.s_wr    = 1'b0;
    bus.s_size  = 2'd0;
    bus.s_addr  = 32'd0;
    bus.s_wdata = 32'd0;

    if (!reset) begin
      case (state)
        IDLE: begin
          if (!full) begin
            if (bus.data_req)      grant = G_DATA;
            else if (bus.inst_req) grant = G_INST;
          end
        end
        HOLD_I:  grant = G_INST;
        HOLD_D:  grant = G_DATA;
        default: grant = G_NONE;
      endcase
    end

    case (grant)
      G_DATA: begin
        bus.s_req   = bus.data_req;
        bus.s_wr    = bus.data_wr;
        bus.s_size  = bus.data_size;
        bus.s_addr  = bus.data_addr;
        bus.s_wdata = bus.data_wdata;
      end
      G_INST: begin
        bus.s_req   = bus.inst_req;
        bus.s_wr    = bus.inst_wr;
        bus.s_size  = bus.inst_size;
        bus.s_addr  = bus.inst_addr;
        bus.s_wdata = bus.inst_wdata;
      end
      default: ;
    endcase

    // A presented-but-stalled request locks the owner until memory accepts it
    if (bus.s_req && !bus.s_addr_ok)
      state_nxt = (grant == G_DATA) ? HOLD_D : HOLD_I;
    else if (bus.s_req && bus.s_addr_ok)
      state_nxt = IDLE;
  end

  assign push              = bus.s_req && bus.s_addr_ok;
  assign bus.inst_addr_ok  = push && (grant == G_INST);
  assign bus.data_addr_ok  = push && (grant == G_DATA);
  assign bus.inst_data_ok  = pop && !head_owner;
  assign bus.data_data_ok  = pop && head_owner;
  assign bus.inst_rdata    = bus.s_rdata;
  assign bus.data_rdata    = bus.s_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      owner_q   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      err_unexp <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) begin
        owner_q[wr_ptr] <= (grant == G_DATA);
        wr_ptr          <= wr_ptr + 1'b1;
      end
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (bus.s_data_ok && (count == '0))
        err_unexp <= 1'b1;
    end
  end

endmodule
